// File: rtl/segment_value_sampler_pkg.sv
// Shared types and defaults for the segment value sampler and its LFSR.
package segment_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DRAW = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_LFSR_TAPS   = 32'h8020_0003;
  localparam int unsigned DEFAULT_MAX_RETRIES = 8;

  // Ceiling log2; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Retry counter width, never narrower than one bit.
  function automatic int unsigned retry_width(input int unsigned max_retries);
    return (clog2(max_retries) == 0) ? 1 : clog2(max_retries);
  endfunction

endpackage

// File: rtl/segment_value_sampler_lfsr.sv
// Galois LFSR (right shifting). A zero seed would lock up, so it loads 1 instead.
module galois_lfsr
  import segment_sampler_pkg::*;
#(
  parameter int          WIDTH = 31,
  parameter logic [WIDTH:0] TAPS = (WIDTH+1)'(DEFAULT_LFSR_TAPS)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [WIDTH:0] seed,
  input  logic           step,
  output logic [WIDTH:0] state
);

  logic [WIDTH:0] state_q;
  logic [WIDTH:0] state_d;

  // One Galois step when requested, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (step) state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
  end

  // Seed on reset, substituting 1 for an all-zero seed.
  always_ff @(posedge clock) begin
    if (reset) state_q <= (seed == '0) ? {{WIDTH{1'b0}}, 1'b1} : seed;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/segment_value_sampler.sv
// Draws a uniform value inside the chosen [lower,upper] segment by LFSR
// rejection sampling, falling back to cand>>1 after MAX_RETRIES rejections.
module segment_value_sampler
  import segment_sampler_pkg::*;
#(
  parameter int          WIDTH       = 31,
  parameter logic [WIDTH:0] LFSR_TAPS = (WIDTH+1)'(DEFAULT_LFSR_TAPS),
  parameter int unsigned MAX_RETRIES = DEFAULT_MAX_RETRIES
) (
  input  logic           in_clock,
  input  logic           in_reset,
  input  logic           in_enable,
  input  logic           in_start,
  input  logic [1:0]     in_segment_number,
  input  logic [WIDTH:0] in_lower0,
  input  logic [WIDTH:0] in_lower1,
  input  logic [WIDTH:0] in_lower2,
  input  logic [WIDTH:0] in_lower3,
  input  logic [WIDTH:0] in_upper0,
  input  logic [WIDTH:0] in_upper1,
  input  logic [WIDTH:0] in_upper2,
  input  logic [WIDTH:0] in_upper3,
  input  logic [WIDTH:0] in_seed,
  output logic [WIDTH:0] out_value,
  output logic           out_valid,
  output logic           out_busy,
  output logic           out_fallback,
  output logic           out_error
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned RW = retry_width(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

  state_e         state_q, state_d;
  logic [WIDTH:0] lo_q, lo_d;
  logic [WIDTH:0] range_q, range_d;
  logic [WIDTH:0] mask_q, mask_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [WIDTH:0] value_q, value_d;
  logic           valid_q, valid_d;
  logic           fallback_q, fallback_d;
  logic           error_q, error_d;

  logic [WIDTH:0] sel_lo, sel_hi;
  logic [WIDTH:0] smear;
  logic [WIDTH:0] lfsr_state;
  logic [WIDTH:0] cand;
  logic           lfsr_advance;

  galois_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clock (in_clock),
    .reset (in_reset),
    .seed  (in_seed),
    .step  (lfsr_advance),
    .state (lfsr_state)
  );

  // Bound mux for the chosen segment.
  always_comb begin
    sel_lo = in_lower0;
    sel_hi = in_upper0;
    case (in_segment_number)
      2'd0: begin sel_lo = in_lower0; sel_hi = in_upper0; end
      2'd1: begin sel_lo = in_lower1; sel_hi = in_upper1; end
      2'd2: begin sel_lo = in_lower2; sel_hi = in_upper2; end
      2'd3: begin sel_lo = in_lower3; sel_hi = in_upper3; end
      default: ;
    endcase
  end

  // Bit-smear of the range: smallest 2^k-1 covering it (0 stays 0).
  always_comb begin
    smear = range_q;
    for (int unsigned s = 1; s < DW; s = s * 2) smear = smear | (smear >> s);
  end

  assign cand = lfsr_state & mask_q;

  // Next-state and registered-output logic; everything holds while disabled.
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    range_d      = range_q;
    mask_d       = mask_q;
    retry_d      = retry_q;
    value_d      = value_q;
    valid_d      = valid_q;
    fallback_d   = fallback_q;
    error_d      = error_q;
    lfsr_advance = 1'b0;
    if (in_enable) begin
      valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_start) begin
            lo_d = sel_lo;
            if (sel_hi < sel_lo) begin
              value_d    = sel_lo;
              error_d    = 1'b1;
              fallback_d = 1'b0;
              valid_d    = 1'b1;
            end else begin
              range_d = sel_hi - sel_lo;
              retry_d = '0;
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          mask_d  = smear;
          state_d = ST_DRAW;
        end
        ST_DRAW: begin
          lfsr_advance = 1'b1;
          if (cand <= range_q) begin
            value_d    = lo_q + cand;
            valid_d    = 1'b1;
            fallback_d = 1'b0;
            error_d    = 1'b0;
            state_d    = ST_IDLE;
          end else if (retry_q == RETRY_LAST) begin
            // cand>>1 <= mask>>1 <= range, so the fallback stays in the segment.
            value_d    = lo_q + (cand >> 1);
            valid_d    = 1'b1;
            fallback_d = 1'b1;
            error_d    = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset wins over enable.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= ST_IDLE;
      lo_q       <= '0;
      range_q    <= '0;
      mask_q     <= '0;
      retry_q    <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      range_q    <= range_d;
      mask_q     <= mask_d;
      retry_q    <= retry_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
      error_q    <= error_d;
    end
  end

  assign out_value    = value_q;
  assign out_valid    = valid_q;
  assign out_busy     = (state_q != ST_IDLE);
  assign out_fallback = fallback_q;
  assign out_error    = error_q;

endmodule

// File: tb/tb_segment_value_sampler.sv
// Randomized bench for segment_value_sampler against a behavioural reference model.
module tb_segment_value_sampler;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst, en, start_a, start_b;
  logic [1:0]  seg;
  logic [31:0] lo_v [4];
  logic [31:0] hi_v [4];
  logic [31:0] seed;

  logic [31:0] a_value, b_value;
  logic        a_valid, a_busy, a_fb, a_err;
  logic        b_valid, b_busy, b_fb, b_err;

  int n_pass = 0;
  int n_checks = 0;
  logic [31:0] lfsr_m [2];
  int hist [8];

  always #5 clk = ~clk;

  segment_value_sampler #(.WIDTH(31), .LFSR_TAPS(TAPS), .MAX_RETRIES(8)) dut_a (
    .in_clock(clk), .in_reset(rst), .in_enable(en), .in_start(start_a),
    .in_segment_number(seg),
    .in_lower0(lo_v[0]), .in_lower1(lo_v[1]), .in_lower2(lo_v[2]), .in_lower3(lo_v[3]),
    .in_upper0(hi_v[0]), .in_upper1(hi_v[1]), .in_upper2(hi_v[2]), .in_upper3(hi_v[3]),
    .in_seed(seed), .out_value(a_value), .out_valid(a_valid), .out_busy(a_busy),
    .out_fallback(a_fb), .out_error(a_err));

  segment_value_sampler #(.WIDTH(31), .LFSR_TAPS(TAPS), .MAX_RETRIES(1)) dut_b (
    .in_clock(clk), .in_reset(rst), .in_enable(en), .in_start(start_b),
    .in_segment_number(seg),
    .in_lower0(lo_v[0]), .in_lower1(lo_v[1]), .in_lower2(lo_v[2]), .in_lower3(lo_v[3]),
    .in_upper0(hi_v[0]), .in_upper1(hi_v[1]), .in_upper2(hi_v[2]), .in_upper3(hi_v[3]),
    .in_seed(seed), .out_value(b_value), .out_valid(b_valid), .out_busy(b_busy),
    .out_fallback(b_fb), .out_error(b_err));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] seeded(input logic [31:0] s);
    return (s == 0) ? 32'd1 : s;
  endfunction

  // Reference: mask is the smallest all-ones number covering the range; up to
  // maxr draws, accept cand<=range, otherwise the last draw falls back to cand/2.
  task automatic model(input logic [31:0] lo, input logic [31:0] hi, input int maxr,
                       inout logic [31:0] l, output logic [31:0] v,
                       output bit fb, output bit err, output int draws);
    logic [31:0] range, mask, cand;
    fb = 0; err = 0; draws = 0; v = lo;
    if (hi < lo) begin
      err = 1;
      return;
    end
    range = hi - lo;
    mask = 0;
    while (mask < range) mask = (mask << 1) | 32'd1;
    for (int k = 1; k <= maxr; k++) begin
      cand = l & mask;
      l = lfsr_next(l);
      draws = k;
      if (cand <= range) begin
        v = lo + cand;
        return;
      end
      if (k == maxr) begin
        v = lo + cand / 2;
        fb = 1;
        return;
      end
    end
  endtask

  // One request on dut_a (which=0) or dut_b (which=1); optional stall and busy poke.
  task automatic run_req(input int which, input logic [1:0] s, input int stall_at,
                         input bit poke, output logic [31:0] got);
    logic [31:0] ev;
    bit efb, eerr;
    int draws, cyc, exp_lat;
    logic [31:0] l;
    l = lfsr_m[which];
    model(lo_v[s], hi_v[s], (which != 0) ? 1 : 8, l, ev, efb, eerr, draws);
    lfsr_m[which] = l;
    exp_lat = eerr ? 1 : 2 + draws + ((stall_at != 0) ? 5 : 0);
    @(negedge clk);
    seg = s;
    if (which != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cyc = 1;
    while (!((which != 0) ? b_valid : a_valid) && cyc < 64) begin
      if (poke && cyc == 1) begin
        check("poke_busy", a_busy, 1'b1);
        start_a = 1'b1;
        seg = s + 2'd1;
      end
      if (stall_at != 0 && cyc == stall_at) begin
        en = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_hold", {a_valid, a_busy}, 2'b01);
        en = 1'b1;
        cyc += 5;
      end
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      seg = s;
    end
    got = (which != 0) ? b_value : a_value;
    check("valid_seen", (which != 0) ? b_valid : a_valid, 1'b1);
    check("latency", cyc, exp_lat);
    check("value", got, ev);
    check("fallback", (which != 0) ? b_fb : a_fb, efb);
    check("error", (which != 0) ? b_err : a_err, eerr);
    if (eerr) check("err_busy", (which != 0) ? b_busy : a_busy, 1'b0);
    @(negedge clk);
    check("valid_pulse", (which != 0) ? b_valid : a_valid, 1'b0);
  endtask

  task automatic do_reset(input logic [31:0] sd);
    seed = sd;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lfsr_m[0] = seeded(sd);
    lfsr_m[1] = seeded(sd);
  endtask

  initial begin
    logic [31:0] got;
    int fbcnt, mode, sh;
    logic [32:0] wide;
    rst = 1'b1; en = 1'b1; start_a = 1'b0; start_b = 1'b0; seg = 2'd0; seed = 32'd1;
    for (int i = 0; i < 4; i++) begin lo_v[i] = 0; hi_v[i] = 0; end
    for (int i = 0; i < 8; i++) hist[i] = 0;
    do_reset(32'd1);
    check("rst_a", {a_value, a_valid, a_busy, a_fb, a_err}, '0);
    check("rst_b", {b_value, b_valid, b_busy, b_fb, b_err}, '0);

    // Uniform draws over 100..107.
    lo_v[2] = 100; hi_v[2] = 107;
    for (int i = 0; i < 1000; i++) begin
      run_req(0, 2'd2, 0, 1'b0, got);
      if (got >= 100 && got <= 107) hist[got - 100]++;
    end
    for (int i = 0; i < 8; i++) check("hist_bin", (hist[i] >= 85 && hist[i] <= 165), 1'b1);

    // Degenerate range and inverted bounds.
    lo_v[1] = 55; hi_v[1] = 55;
    run_req(0, 2'd1, 0, 1'b0, got);
    lo_v[0] = 10; hi_v[0] = 5;
    run_req(0, 2'd0, 0, 1'b0, got);

    // Single-retry instance: fallback must occur and stay <= 4.
    do_reset($urandom);
    lo_v[3] = 0; hi_v[3] = 4;
    fbcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      run_req(1, 2'd3, 0, 1'b0, got);
      if (b_fb) fbcnt++;
      if (got > 4) check("b_range", got, 32'd4);
    end
    check("fb_seen", fbcnt > 0, 1'b1);

    // Reset mid-DRAW (zero seed) aborts the request.
    @(negedge clk);
    seg = 2'd2; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check("draw_busy", a_busy, 1'b1);
    seed = 32'd0; rst = 1'b1;
    @(negedge clk);
    check("abort", {a_valid, a_busy, a_value}, '0);
    rst = 1'b0;
    lfsr_m[0] = 32'd1; lfsr_m[1] = 32'd1;

    // Busy poke, stall mid-DRAW, full-width range.
    run_req(0, 2'd2, 0, 1'b1, got);
    run_req(0, 2'd2, 2, 1'b0, got);
    lo_v[0] = 0; hi_v[0] = 32'hFFFF_FFFF;
    run_req(0, 2'd0, 0, 1'b0, got);

    // Random bounds.
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 4; j++) begin
        mode = $urandom_range(0, 5);
        lo_v[j] = $urandom;
        if (mode == 0) hi_v[j] = lo_v[j];
        else if (mode == 1) begin
          if (lo_v[j] == 0) lo_v[j] = 1;
          hi_v[j] = lo_v[j] - $urandom_range(1, 1000);
          if (hi_v[j] >= lo_v[j]) hi_v[j] = 0;
        end else if (mode == 2) begin
          lo_v[j] = 0; hi_v[j] = 32'hFFFF_FFFF;
        end else begin
          sh = $urandom_range(0, 31);
          wide = {1'b0, lo_v[j]} + {1'b0, ($urandom >> sh)};
          hi_v[j] = wide[32] ? 32'hFFFF_FFFF : wide[31:0];
        end
      end
      run_req(0, 2'($urandom_range(0, 3)), ((i % 37) == 5) ? 2 : 0, (i % 23) == 7, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
